// File: rtl/inst_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_pkg
// Shared definitions for the MIPS32 IF stage: default reset PC and NOP word,
// address/instruction bus widths, the 2-bit fetch-state encoding and a small
// alignment helper used by both the PC generator and the IF/ID capture logic.
// -----------------------------------------------------------------------------
package inst_fetch_unit_pkg;

   localparam int unsigned INST_ADDR_W = 32;
   localparam int unsigned INST_W      = 32;
   localparam int unsigned RAM_ADDR_W  = 20;

   localparam logic [INST_ADDR_W-1:0] RESET_PC_DEF = 32'h8000_0000;
   localparam logic [INST_W-1:0]      NOP_INST_DEF = 32'h0000_0000;

   // Fetch state: running, stalled with nothing pending, stalled with a
   // redirect target captured while stalled.
   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_STALL = 2'd1,
      S_PEND  = 2'd2
   } if_state_t;

   // A fetch address is misaligned when either of its two low bits is set.
   function automatic logic pc_misaligned(input logic [INST_ADDR_W-1:0] pc);
      return (pc[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/inst_fetch_unit_if_pc_gen.sv
// -----------------------------------------------------------------------------
// if_pc_gen
// PC register, next-PC priority mux and the stall/pending-redirect FSM.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   stall_i            hold the PC this cycle
//   flush_i/flush_pc_i exception redirect, highest priority after rst
//   branch_valid_i     taken branch resolved in ID, target in branch_target_i
//   pc_o               current fetch PC (registered)
// -----------------------------------------------------------------------------
module if_pc_gen
   import inst_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   input  logic        branch_valid_i,
   input  logic [31:0] branch_target_i,
   output logic [31:0] pc_o
);

   logic [31:0] pc_r;
   logic [31:0] pend_target_r;
   if_state_t   state_r;
   logic [31:0] next_pc_s;

   // Next fetch PC when the stage advances: a live branch beats a target
   // captured during a stall, which beats sequential fetch (wraps at 2^32).
   always_comb begin
      next_pc_s = pc_r + 32'd4;
      if (branch_valid_i) begin
         next_pc_s = branch_target_i;
      end else if (state_r == S_PEND) begin
         next_pc_s = pend_target_r;
      end else begin
         next_pc_s = pc_r + 32'd4;
      end
   end

   // PC register and fetch FSM: flush > stall > run.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r          <= RESET_PC;
         pend_target_r <= 32'd0;
         state_r       <= S_RUN;
      end else if (flush_i) begin
         pc_r          <= flush_pc_i;
         pend_target_r <= 32'd0;
         state_r       <= S_RUN;
      end else if (stall_i) begin
         // The delay-slot word is still fetched from the held PC, so a branch
         // seen while stalled only becomes the PC after the stall releases.
         if (branch_valid_i) begin
            pend_target_r <= branch_target_i;
            state_r       <= S_PEND;
         end else begin
            case (state_r)
               S_PEND:  state_r <= S_PEND;
               S_RUN:   state_r <= S_STALL;
               S_STALL: state_r <= S_STALL;
               default: state_r <= S_STALL;
            endcase
         end
      end else begin
         pc_r          <= next_pc_s;
         pend_target_r <= 32'd0;
         state_r       <= S_RUN;
      end
   end

   assign pc_o = pc_r;

endmodule

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// IF stage of the MIPS32 pipeline. Owns the PC (via if_pc_gen), drives the
// SRAM word address and captures {pc, inst, valid, adel} into the IF/ID
// register. SRAM data returns in the same cycle as the address, so an
// instruction appears on inst_o one clock after its PC.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   stall_i                          hold PC and IF/ID outputs
//   flush_i, flush_pc_i              exception/eret redirect
//   branch_valid_i, branch_target_i  taken branch from ID
//   ram_addr_o                       SRAM word address (pc[21:2])
//   ram_data_i                       instruction word from SRAM
//   pc_o, inst_o, inst_valid_o, adel_o  IF/ID register outputs
// -----------------------------------------------------------------------------
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   input  logic        branch_valid_i,
   input  logic [31:0] branch_target_i,
   output logic [19:0] ram_addr_o,
   input  logic [31:0] ram_data_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        inst_valid_o,
   output logic        adel_o
);

   logic [31:0] pc_s;
   logic        misaligned_s;
   logic [31:0] pc_out_r;
   logic [31:0] inst_r;
   logic        inst_valid_r;
   logic        adel_r;

   if_pc_gen #(
      .RESET_PC (RESET_PC)
   ) u_pc_gen (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall_i),
      .flush_i         (flush_i),
      .flush_pc_i      (flush_pc_i),
      .branch_valid_i  (branch_valid_i),
      .branch_target_i (branch_target_i),
      .pc_o            (pc_s)
   );

   // Address is driven even when misaligned; the returned word is discarded.
   assign ram_addr_o   = pc_s[21:2];
   assign misaligned_s = pc_misaligned(pc_s);

   // IF/ID capture register: flush injects a bubble, stall holds, run samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_out_r     <= 32'd0;
         inst_r       <= NOP_INST;
         inst_valid_r <= 1'b0;
         adel_r       <= 1'b0;
      end else if (flush_i) begin
         inst_r       <= NOP_INST;
         inst_valid_r <= 1'b0;
         adel_r       <= 1'b0;
      end else if (stall_i) begin
         pc_out_r     <= pc_out_r;
         inst_r       <= inst_r;
         inst_valid_r <= inst_valid_r;
         adel_r       <= adel_r;
      end else begin
         // A faulting fetch is still delivered as valid so ID can raise AdEL.
         pc_out_r     <= pc_s;
         inst_r       <= misaligned_s ? NOP_INST : ram_data_i;
         inst_valid_r <= 1'b1;
         adel_r       <= misaligned_s;
      end
   end

   assign pc_o         = pc_out_r;
   assign inst_o       = inst_r;
   assign inst_valid_o = inst_valid_r;
   assign adel_o       = adel_r;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic        branch_valid_i;
   logic [31:0] branch_target_i;
   logic [19:0] ram_addr_o;
   logic [31:0] ram_data_i;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        inst_valid_o;
   logic        adel_o;

   int total;
   int bad;

   inst_fetch_unit dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall_i),
      .flush_i         (flush_i),
      .flush_pc_i      (flush_pc_i),
      .branch_valid_i  (branch_valid_i),
      .branch_target_i (branch_target_i),
      .ram_addr_o      (ram_addr_o),
      .ram_data_i      (ram_data_i),
      .pc_o            (pc_o),
      .inst_o          (inst_o),
      .inst_valid_o    (inst_valid_o),
      .adel_o          (adel_o)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // SRAM model: word content tags the address it came from.
   always_comb ram_data_i = {12'hA5A, ram_addr_o};

   function automatic logic [31:0] mem_word(input logic [31:0] pc);
      logic [31:0] p;
      p = pc;
      return {12'hA5A, p[21:2]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                           input logic e_valid, input logic e_adel);
      chk({tag, ".pc"},    pc_o,                  e_pc);
      chk({tag, ".inst"},  inst_o,                e_inst);
      chk({tag, ".valid"}, {31'd0, inst_valid_o}, {31'd0, e_valid});
      chk({tag, ".adel"},  {31'd0, adel_o},       {31'd0, e_adel});
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      stall_i = 1'b0;
      flush_i = 1'b0;
      flush_pc_i = 32'd0;
      branch_valid_i = 1'b0;
      branch_target_i = 32'd0;
      step();
      step();
      chk_ifid("reset", 32'd0, 32'h0000_0000, 1'b0, 1'b0);
      chk("reset.addr", {12'd0, ram_addr_o}, 32'h0000_0000);
      rst = 1'b0;

      // Sequential fetch after reset release
      step();
      chk_ifid("seq0", 32'h8000_0000, mem_word(32'h8000_0000), 1'b1, 1'b0);
      chk("seq0.addr", {12'd0, ram_addr_o}, 32'h0000_0001);
      step();
      chk_ifid("seq1", 32'h8000_0004, mem_word(32'h8000_0004), 1'b1, 1'b0);

      // Branch at pc 0x80000008: delay slot delivered, then target
      branch_valid_i = 1'b1;
      branch_target_i = 32'h8000_0100;
      step();
      chk_ifid("dslot", 32'h8000_0008, mem_word(32'h8000_0008), 1'b1, 1'b0);
      chk("br.addr", {12'd0, ram_addr_o}, 32'h0000_0040);
      branch_valid_i = 1'b0;
      step();
      chk_ifid("brtgt", 32'h8000_0100, mem_word(32'h8000_0100), 1'b1, 1'b0);
      step();
      step();
      step();
      chk("pre_stall.pc", pc_o, 32'h8000_010C);

      // Stall three cycles with pc 0x80000110
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_ifid("stall", 32'h8000_010C, mem_word(32'h8000_010C), 1'b1, 1'b0);
         chk("stall.addr", {12'd0, ram_addr_o}, 32'h0000_0044);
      end
      stall_i = 1'b0;
      step();
      chk_ifid("resume", 32'h8000_0110, mem_word(32'h8000_0110), 1'b1, 1'b0);
      step();
      chk("resume2.pc", pc_o, 32'h8000_0114);

      // Branch while stalled (pc 0x80000118) -> pending
      stall_i = 1'b1;
      branch_valid_i = 1'b1;
      branch_target_i = 32'h8000_0200;
      step();
      branch_valid_i = 1'b0;
      step();
      chk("pend_hold.pc", pc_o, 32'h8000_0114);
      stall_i = 1'b0;
      step();
      chk_ifid("pend_dslot", 32'h8000_0118, mem_word(32'h8000_0118), 1'b1, 1'b0);
      step();
      chk_ifid("pend_tgt", 32'h8000_0200, mem_word(32'h8000_0200), 1'b1, 1'b0);

      // Second branch while pending overwrites the target (pc 0x80000204)
      stall_i = 1'b1;
      branch_valid_i = 1'b1;
      branch_target_i = 32'h8000_0300;
      step();
      branch_target_i = 32'h8000_0400;
      step();
      branch_valid_i = 1'b0;
      stall_i = 1'b0;
      step();
      chk("ovw_dslot.pc", pc_o, 32'h8000_0204);
      step();
      chk_ifid("ovw_tgt", 32'h8000_0400, mem_word(32'h8000_0400), 1'b1, 1'b0);

      // Flush during stall with a pending redirect
      stall_i = 1'b1;
      branch_valid_i = 1'b1;
      branch_target_i = 32'h8000_0500;
      step();
      branch_valid_i = 1'b0;
      flush_i = 1'b1;
      flush_pc_i = 32'h8000_1180;
      step();
      chk("flush.inst", inst_o, 32'h0000_0000);
      chk("flush.valid", {31'd0, inst_valid_o}, 32'd0);
      chk("flush.addr", {12'd0, ram_addr_o}, 32'h0000_0460);
      flush_i = 1'b0;
      stall_i = 1'b0;
      step();
      chk_ifid("flush_tgt", 32'h8000_1180, mem_word(32'h8000_1180), 1'b1, 1'b0);
      step();
      chk("flush_seq.pc", pc_o, 32'h8000_1184);

      // Branch to a misaligned target
      branch_valid_i = 1'b1;
      branch_target_i = 32'h8000_0102;
      step();
      chk("mis_dslot.pc", pc_o, 32'h8000_1188);
      branch_valid_i = 1'b0;
      step();
      chk_ifid("mis0", 32'h8000_0102, 32'h0000_0000, 1'b1, 1'b1);
      chk("mis0.addr", {12'd0, ram_addr_o}, 32'h0000_0041);
      step();
      chk_ifid("mis1", 32'h8000_0106, 32'h0000_0000, 1'b1, 1'b1);
      flush_i = 1'b1;
      flush_pc_i = 32'h8000_1180;
      step();
      chk("mis_flush.adel", {31'd0, adel_o}, 32'd0);
      chk("mis_flush.valid", {31'd0, inst_valid_o}, 32'd0);
      flush_i = 1'b0;
      step();
      chk_ifid("mis_recover", 32'h8000_1180, mem_word(32'h8000_1180), 1'b1, 1'b0);

      // PC wrap 0xFFFFFFFC -> 0
      flush_i = 1'b1;
      flush_pc_i = 32'hFFFF_FFFC;
      step();
      chk("wrap.addr0", {12'd0, ram_addr_o}, 32'h000F_FFFF);
      flush_i = 1'b0;
      step();
      chk_ifid("wrap0", 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1'b1, 1'b0);
      chk("wrap.addr1", {12'd0, ram_addr_o}, 32'h0000_0000);
      step();
      chk_ifid("wrap1", 32'h0000_0000, mem_word(32'h0000_0000), 1'b1, 1'b0);

      // Reset while a redirect is pending
      stall_i = 1'b1;
      branch_valid_i = 1'b1;
      branch_target_i = 32'h8000_0700;
      step();
      branch_valid_i = 1'b0;
      rst = 1'b1;
      step();
      chk_ifid("rst_pend", 32'd0, 32'h0000_0000, 1'b0, 1'b0);
      rst = 1'b0;
      stall_i = 1'b0;
      step();
      chk_ifid("rst_pend_run", 32'h8000_0000, mem_word(32'h8000_0000), 1'b1, 1'b0);
      step();
      chk("rst_pend_seq.pc", pc_o, 32'h8000_0004);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
